// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, syncs, visible flag and line/frame strobes.
// All outputs come from the next-position values and are registered together, so they line up on the same pixel.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10-bit counters");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync region ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_VIS_END = 11'(H_DISPLAY);
    localparam logic [10:0] HS_START  = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_DISPLAY);
    localparam logic [10:0] VS_START  = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    logic        h_wrap;
    logic        v_wrap;
    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic [10:0] h_next_w;
    logic [10:0] v_next_w;

    always_comb begin
        h_wrap   = (hpos == H_LAST);
        v_wrap   = (vpos == V_LAST);
        h_next   = h_wrap ? 10'd0 : hpos + 10'd1;
        v_next   = vpos;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vpos + 10'd1;
        end
        h_next_w = {1'b0, h_next};
        v_next_w = {1'b0, v_next};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos        <= '0;
            vpos        <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            visible     <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                hpos        <= h_next;
                vpos        <= v_next;
                hsync       <= (h_next_w >= HS_START && h_next_w < HS_END) ? SYNC_POL : ~SYNC_POL;
                vsync       <= (v_next_w >= VS_START && v_next_w < VS_END) ? SYNC_POL : ~SYNC_POL;
                visible     <= (h_next_w < H_VIS_END) && (v_next_w < V_VIS_END);
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
                if (h_wrap && v_wrap) begin
                    frame_count <= frame_count + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size 640x480 instance and a tiny-geometry instance share one randomized stimulus stream;
// expected outputs are derived arithmetically from the count of enabled cycles since reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] b_hpos, b_vpos, b_fc;
    logic       b_hs, b_vs, b_vis, b_ls, b_fs;
    logic [9:0] s_hpos, s_vpos, s_fc;
    logic       s_hs, s_vs, s_vis, s_ls, s_fs;

    vga_timing_gen u_big (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hs), .vsync(b_vs), .visible(b_vis),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    // 8 x 6 raster: a frame is 48 enabled cycles, so 1024 frames fit comfortably
    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hs), .vsync(s_vs), .visible(s_vis),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vis;
        logic       ls;
        logic       fs;
        logic [9:0] fc;
    } obs_t;

    obs_t q_big[$];
    obs_t q_small[$];

    int  n_chk  = 0;
    int  n_fail = 0;
    longint t_adv = 0;

    // Position after t enabled cycles since reset, from raster arithmetic alone.
    function automatic obs_t model(longint t, bit strobe, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb);
        obs_t e;
        int ht, vt, h, v;
        longint ft;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        ft = longint'(ht) * vt;
        h  = int'(t % ht);
        v  = int'((t / ht) % vt);
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.hs  = (h >= hd + hf && h < hd + hf + hsw) ? 1'b0 : 1'b1;
        e.vs  = (v >= vd + vf && v < vd + vf + vsw) ? 1'b0 : 1'b1;
        e.vis = (h < hd) && (v < vd);
        e.ls  = strobe && (h == 0);
        e.fs  = strobe && (h == 0) && (v == 0);
        e.fc  = 10'((t / ft) % 1024);
        return e;
    endfunction

    task automatic step(input bit r, input bit c);
        bit strobe;
        @(negedge clk);
        rst_n = r;
        ce    = c;
        strobe = 1'b0;
        if (!r) begin
            t_adv = 0;
        end else if (c) begin
            t_adv++;
            strobe = 1'b1;
        end
        q_big.push_back(model(t_adv, strobe, 640, 16, 96, 48, 480, 10, 2, 33));
        q_small.push_back(model(t_adv, strobe, 4, 1, 2, 1, 3, 1, 1, 1));
    endtask

    always @(posedge clk) begin
        obs_t e, a;
        #1;
        if (q_big.size() > 0) begin
            e = q_big.pop_front();
            a = {b_hpos, b_vpos, b_hs, b_vs, b_vis, b_ls, b_fs, b_fc};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL big_raster t=%0t: got h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b fc=%0d",
                         $time, a.h, a.v, a.hs, a.vs, a.vis, a.ls, a.fs, a.fc,
                         e.h, e.v, e.hs, e.vs, e.vis, e.ls, e.fs, e.fc);
            end
        end
        if (q_small.size() > 0) begin
            e = q_small.pop_front();
            a = {s_hpos, s_vpos, s_hs, s_vs, s_vis, s_ls, s_fs, s_fc};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL small_raster t=%0t: got h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b fc=%0d",
                         $time, a.h, a.v, a.hs, a.vs, a.vis, a.ls, a.fs, a.fc,
                         e.h, e.v, e.hs, e.vs, e.vis, e.ls, e.fs, e.fc);
            end
        end
    end

    initial begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        // free-running: big instance crosses 639/640, 656, 752 and 799->0 twice
        repeat (1700) step(1'b1, 1'b1);
        // alternating enable: a big line takes 1600 cycles
        for (int i = 0; i < 3400; i++) step(1'b1, (i % 2) == 0);
        // random enable
        repeat (2000) step(1'b1, 1'($urandom_range(0, 1)));
        // reset one cycle at big hpos=300, overriding an asserted ce
        while ((t_adv % 800) != 300) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (20) step(1'b1, 1'($urandom_range(0, 1)));
        // random mid-frame reset on the small raster
        repeat (37) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        // 1024+ small frames: frame_count wraps 1023->0
        repeat (1024 * 48 + 100) step(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        n_chk++;
        if (q_big.size() != 0 || q_small.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d/%0d entries left, expected 0/0", q_big.size(), q_small.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
